ldm_stm_sequencer: RTL and testbench
====================================

// Module: ldm_stm_sequencer
// PURPOSE
//  Multi-register transfer sequencer for LDM/STM/PUSH/POP, upstream of the MEM address mux.
//  Drives multiple_working/addr_dm_out into that mux, one word address per transfer.
//  Names the register being loaded or stored each transfer.
//  Issues the final base writeback (Rn or SP) to the register file.
// PARAMETERS
//  ADDR_W   32  address/data width
//  LIST_W   9   register-list width: bits[7:0]=R0..R7, bit[8]=LR (PUSH) / PC (POP)
// PORTS
//  clk              in   1   core clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  start            in   1   one-cycle decode pulse; accepted only in IDLE
//  op               in   2   `MT_LDM=0, `MT_STM=1, `MT_PUSH=2, `MT_POP=3
//  reg_list         in   9   registers to transfer
//  base_rn          in   3   base register number (LDM/STM); SP(13) is implied for PUSH/POP
//  base_addr        in   32  current base value (Rn or SP), sampled on start
//  mem_ready        in   1   memory completes the current word this cycle
//  multiple_working out  1   high while a transfer address is being presented
//  addr_dm_out      out  32  word address of the current transfer
//  xfer_reg         out  4   register number of the current transfer (0..7, 14, 15)
//  mem_read         out  1   current transfer is a load
//  mem_write        out  1   current transfer is a store
//  rf_load_we       out  1   mem_read & mem_ready: register file captures the load data
//  wb_we            out  1   one-cycle base writeback strobe
//  wb_reg           out  4   writeback register number
//  wb_value         out  32  new base value
//  done             out  1   one-cycle end pulse; the pipeline may advance
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0. Latched list, address and count are cleared.
//  Reset mid-operation aborts at once; no further strobes are issued.
//  States: IDLE -> XFER -> WB -> IDLE. The empty-list path goes IDLE -> DONE -> IDLE.
//  IDLE, on start:
//   - latch op, list, base_rn and base_addr
//   - cnt = popcount(list)
//   - PUSH: addr = base - 4*cnt. Other ops: addr = base.
//   - if list == 0: go to DONE and pulse done the next cycle (no transfers, no writeback).
//  XFER:
//   - multiple_working=1; addr_dm_out=addr; xfer_reg = lowest set bit of the remaining list.
//   - bit 8 maps to 14 for PUSH and 15 for POP. For LDM/STM, bit 8 is ignored (masked on latch).
//   - mem_read = LDM|POP; mem_write = STM|PUSH; both are held while mem_ready=0 (stall).
//   - on mem_ready: clear that bit and addr += 4. If it was the last bit, go to WB.
//   - the first transfer address appears one cycle after start.
//   - each word takes 1 cycle when mem_ready=1.
//  WB (one cycle):
//   - multiple_working=0; done=1
//   - wb_we=1, except for LDM with base_rn in the list (loaded value wins, no writeback)
//   - wb_reg = base_rn for LDM/STM, 13 for PUSH/POP
//   - wb_value = base + 4*cnt for LDM/STM/POP, and base - 4*cnt for PUSH
//  start outside IDLE is ignored.
//  Address arithmetic is modulo 2^32; the wrap at 0xFFFFFFFC -> 0 is silent.
//  The low 2 bits of base_addr are passed through unchanged; alignment faults are not checked here.
//  POP including PC: xfer_reg=15 on the last transfer, because the list is scanned ascending.
//  The branch is handled by the register file and the PC logic.
// STRUCTURE
//  Shared include file (mt_defs.vh):
//   - `MT_LDM/`MT_STM/`MT_PUSH/`MT_POP
//   - state codes `MT_IDLE/`MT_XFER/`MT_WB/`MT_DONE
//   - register numbers `REG_SP=13, `REG_LR=14, `REG_PC=15
//  Sub-module lowest_set_9: 9-bit lowest-set-bit priority encoder with a valid output.
//  It is used for xfer_reg and for clearing the remaining list.
//  Popcount is inline combinational logic.
// TESTING
//  1. STM R1: base=0x1000, list=0x0B, mem_ready=1
//     -> addr 0x1000/0x1004/0x1008 with xfer_reg 0/1/3, mem_write each cycle
//     -> WB: wb_reg=1, wb_value=0x100C
//  2. PUSH {R4,LR}: SP=0x2000, list=0x110
//     -> addr 0x1FF8 (reg 4), then 0x1FFC (reg 14)
//     -> wb_reg=13, wb_value=0x1FF8
//  3. LDM R2: list=0x06, mem_ready low for 2 cycles on the first word
//     -> addr is held for 3 cycles, rf_load_we only on the ready cycle
//     -> wb_we=0, because R2 is in the list
//  4. POP {R0,PC}: SP=0x3000
//     -> reg 0 at 0x3000, reg 15 at 0x3004
//     -> wb_value=0x3008
//  5. Empty list -> no multiple_working, done one cycle later, wb_we=0.
//     A second start during XFER is ignored.
//  6. rst_n low mid-XFER -> all outputs 0 asynchronously.
//     After release, a new start behaves as in test 1.
//     Base 0xFFFFFFFC with 2 regs -> second address is 0x00000000.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM/PUSH/POP sequencer: operation and state
// codes, architectural register numbers and the register-list popcount.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    MT_LDM  = 2'd0,
    MT_STM  = 2'd1,
    MT_PUSH = 2'd2,
    MT_POP  = 2'd3
  } mt_op_e;

  typedef enum logic [1:0] {
    MT_IDLE = 2'd0,
    MT_XFER = 2'd1,
    MT_WB   = 2'd2,
    MT_DONE = 2'd3
  } mt_state_e;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // Number of registers named in a 9-bit list (0..9).
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_9.sv
// 9-bit lowest-set-bit priority encoder. idx is 0 when no bit is set;
// valid tells the caller whether idx means anything.
module lowest_set_9 (
  input  logic [8:0] vec,
  output logic [3:0] idx,
  output logic       valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = 4'd0;
    valid = |vec;
    for (int i = 8; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register transfer sequencer for LDM/STM/PUSH/POP. Presents one word
// address per transfer to the MEM address mux, names the register moved in
// that transfer, and finishes with a single base-register writeback.
//
// Memory handshake: while multiple_working is high, the address, xfer_reg,
// mem_read and mem_write are held stable until the cycle in which mem_ready
// is high; that cycle completes the word and the next word (or WB) follows.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [2:0]        base_rn,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  output logic              multiple_working,
  output logic [ADDR_W-1:0] addr_dm_out,
  output logic [3:0]        xfer_reg,
  output logic              mem_read,
  output logic              mem_write,
  output logic              rf_load_we,
  output logic              wb_we,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_value,
  output logic              done,
  output logic [1:0]        state_dbg
);

  mt_state_e         state_q, state_d;
  mt_op_e            op_in, op_q;
  logic [8:0]        rem_q;
  logic [2:0]        rn_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [3:0]        cnt_q;
  logic              base_in_list_q;

  logic [8:0]        list_in;
  logic [7:0]        low_list_in;
  logic [3:0]        cnt_in;
  logic [ADDR_W-1:0] off_in, off_q;
  logic [3:0]        lsb_idx;
  logic              lsb_valid;
  logic [8:0]        rem_clr;
  logic              is_load_q;
  logic              is_stack_q;

  assign op_in       = mt_op_e'(op);
  assign low_list_in = reg_list[7:0];
  // LDM/STM have no bit-8 register; drop it as the list is latched.
  assign list_in     = (op_in == MT_LDM || op_in == MT_STM) ? {1'b0, low_list_in} : reg_list;
  assign cnt_in      = popcount9(list_in);
  assign off_in      = {{(ADDR_W-6){1'b0}}, cnt_in, 2'b00};
  assign off_q       = {{(ADDR_W-6){1'b0}}, cnt_q, 2'b00};
  assign is_load_q   = (op_q == MT_LDM) || (op_q == MT_POP);
  assign is_stack_q  = (op_q == MT_PUSH) || (op_q == MT_POP);
  assign state_dbg   = state_q;

  lowest_set_9 u_lowest (
    .vec   (rem_q),
    .idx   (lsb_idx),
    .valid (lsb_valid)
  );

  assign rem_clr = rem_q & ~(9'b1 << lsb_idx);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MT_IDLE;
    else        state_q <= state_d;
  end

  // Operand latch on an accepted start, then walk the list one word per ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= MT_LDM;
      rem_q          <= 9'd0;
      rn_q           <= 3'd0;
      base_q         <= '0;
      addr_q         <= '0;
      cnt_q          <= 4'd0;
      base_in_list_q <= 1'b0;
    end else if (state_q == MT_IDLE && start) begin
      op_q           <= op_in;
      rem_q          <= list_in;
      rn_q           <= base_rn;
      base_q         <= base_addr;
      addr_q         <= (op_in == MT_PUSH) ? base_addr - off_in : base_addr;
      cnt_q          <= cnt_in;
      base_in_list_q <= (op_in == MT_LDM) && low_list_in[base_rn];
    end else if (state_q == MT_XFER && mem_ready && lsb_valid) begin
      rem_q  <= rem_clr;
      addr_q <= addr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
    end
  end

  // Next-state and all outputs; everything idles at zero outside its state.
  always_comb begin
    state_d          = state_q;
    multiple_working = 1'b0;
    addr_dm_out      = '0;
    xfer_reg         = 4'd0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    rf_load_we       = 1'b0;
    wb_we            = 1'b0;
    wb_reg           = 4'd0;
    wb_value         = '0;
    done             = 1'b0;
    case (state_q)
      MT_IDLE: begin
        if (start) state_d = (list_in == 9'd0) ? MT_DONE : MT_XFER;
      end
      MT_XFER: begin
        multiple_working = 1'b1;
        addr_dm_out      = addr_q;
        if (lsb_idx == 4'd8) xfer_reg = (op_q == MT_PUSH) ? REG_LR : REG_PC;
        else                 xfer_reg = lsb_idx;
        mem_read   = is_load_q;
        mem_write  = !is_load_q;
        rf_load_we = is_load_q && mem_ready;
        if (mem_ready && rem_clr == 9'd0) state_d = MT_WB;
      end
      MT_WB: begin
        done     = 1'b1;
        wb_we    = !base_in_list_q;
        wb_reg   = is_stack_q ? REG_SP : {1'b0, rn_q};
        wb_value = (op_q == MT_PUSH) ? base_q - off_q : base_q + off_q;
        state_d  = MT_IDLE;
      end
      MT_DONE: begin
        done    = 1'b1;
        state_d = MT_IDLE;
      end
      default: state_d = MT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: a table of operations with hand-derived
// writeback results, a reference model that queues each expected transfer,
// random operations, and hand sequences for reset abort and ignored start.
module tb_ldm_stm_sequencer;

  localparam logic [1:0] OP_LDM = 2'd0, OP_STM = 2'd1, OP_PUSH = 2'd2, OP_POP = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [8:0]  reg_list = 9'd0;
  logic [2:0]  base_rn = 3'd0;
  logic [31:0] base_addr = 32'd0;
  logic        mem_ready = 1'b0;
  logic        multiple_working, mem_read, mem_write, rf_load_we, wb_we, done;
  logic [31:0] addr_dm_out, wb_value;
  logic [3:0]  xfer_reg, wb_reg;
  logic [1:0]  state_dbg;

  ldm_stm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .reg_list(reg_list),
    .base_rn(base_rn), .base_addr(base_addr), .mem_ready(mem_ready),
    .multiple_working(multiple_working), .addr_dm_out(addr_dm_out),
    .xfer_reg(xfer_reg), .mem_read(mem_read), .mem_write(mem_write),
    .rf_load_we(rf_load_we), .wb_we(wb_we), .wb_reg(wb_reg),
    .wb_value(wb_value), .done(done), .state_dbg(state_dbg)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  list;
    logic [2:0]  rn;
    logic [31:0] base;
    int          stall;
    bit          restart;
    logic        wb_we;
    logic [3:0]  wb_reg;
    logic [31:0] wb_value;
  } vec_t;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [37:0] exp_q[$];   // {addr[31:0], reg[3:0], rd, wr}
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " addr"}, addr_dm_out, 32'd0);
    check({tag, " wb_value"}, wb_value, 32'd0);
    check({tag, " ctl"}, {18'd0, multiple_working, xfer_reg, mem_read, mem_write,
                          rf_load_we, wb_we, wb_reg, done}, 32'd0);
    check({tag, " state"}, {30'd0, state_dbg}, 32'd0);
  endtask

  function automatic logic [8:0] eff_list(input logic [1:0] o, input logic [8:0] l);
    return (o == OP_LDM || o == OP_STM) ? {1'b0, l[7:0]} : l;
  endfunction

  function automatic int count_bits(input logic [8:0] m);
    int c = 0;
    for (int i = 0; i < 9; i++) if (m[i]) c++;
    return c;
  endfunction

  // Queue one expected transfer per listed register, in ascending order.
  task automatic load_model(input vec_t v, output int words);
    logic [8:0]  m;
    logic [31:0] a;
    logic [3:0]  r;
    logic        rd;
    m     = eff_list(v.op, v.list);
    words = count_bits(m);
    a     = (v.op == OP_PUSH) ? v.base - 32'(4 * words) : v.base;
    rd    = (v.op == OP_LDM) || (v.op == OP_POP);
    for (int i = 0; i < 9; i++) begin
      if (m[i]) begin
        r = (i < 8) ? 4'(i) : ((v.op == OP_PUSH) ? 4'd14 : 4'd15);
        exp_q.push_back({a, r, rd, !rd});
        a = a + 32'd4;
      end
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [8:0] m;
    int c;
    v.op      = 2'($urandom_range(0, 3));
    v.list    = 9'($urandom_range(0, 511));
    v.rn      = 3'($urandom_range(0, 7));
    v.base    = $urandom;
    v.stall   = $urandom_range(0, 2);
    v.restart = 1'b0;
    m = eff_list(v.op, v.list);
    c = count_bits(m);
    v.wb_we    = (c != 0) && !(v.op == OP_LDM && m[v.rn]);
    v.wb_reg   = (v.op == OP_PUSH || v.op == OP_POP) ? 4'd13 : {1'b0, v.rn};
    v.wb_value = (v.op == OP_PUSH) ? v.base - 32'(4 * c) : v.base + 32'(4 * c);
    return v;
  endfunction

  // Drive one operation and score every transfer and the closing writeback.
  task automatic run_vec(input vec_t v, input string tag);
    int words, stall_left, cycles;
    bit got_done;
    logic [37:0] e;
    exp_q.delete();
    load_model(v, words);
    @(negedge clk);
    op = v.op; reg_list = v.list; base_rn = v.rn; base_addr = v.base;
    mem_ready = 1'b0; start = 1'b1;
    got_done = 0; cycles = 0; stall_left = v.stall;
    while (!got_done && cycles < 64) begin
      @(negedge clk);
      start = v.restart && cycles == 1;
      if (start) begin
        op = OP_PUSH; reg_list = 9'h1FF; base_rn = 3'd5; base_addr = 32'hDEAD0000;
      end
      mem_ready = (stall_left == 0);
      #1;
      if (cycles == 0) check({tag, " first-cycle working"}, {31'd0, multiple_working}, {31'd0, words != 0});
      if (multiple_working) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL %s extra xfer: got addr 0x%08h expected none", tag, addr_dm_out);
        end else begin
          e = exp_q[0];
          check({tag, " addr"}, addr_dm_out, e[37:6]);
          check({tag, " xfer_reg"}, {28'd0, xfer_reg}, {28'd0, e[5:2]});
          check({tag, " rd/wr"}, {30'd0, mem_read, mem_write}, {30'd0, e[1:0]});
          check({tag, " rf_load_we"}, {31'd0, rf_load_we}, {31'd0, e[1] & mem_ready});
          if (mem_ready) void'(exp_q.pop_front());
        end
        if (stall_left > 0) stall_left--;
      end
      if (done) begin
        got_done = 1;
        check({tag, " done latency"}, 32'(cycles), (words == 0) ? 32'd0 : 32'(words + v.stall));
        check({tag, " words left"}, 32'(exp_q.size()), 32'd0);
        check({tag, " working at done"}, {31'd0, multiple_working}, 32'd0);
        check({tag, " wb_we"}, {31'd0, wb_we}, {31'd0, v.wb_we});
        if (words != 0) begin
          check({tag, " wb_reg"}, {28'd0, wb_reg}, {28'd0, v.wb_reg});
          check({tag, " wb_value"}, wb_value, v.wb_value);
        end
      end
      cycles++;
    end
    if (!got_done) begin
      n_vec++; n_fail++;
      $display("FAIL %s timeout: got no done expected done", tag);
    end
    start = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " back idle"}, {30'd0, state_dbg}, 32'd0);
    exp_q.delete();
  endtask

  // Stimulus and final report.
  initial begin
    //          op       list    rn    base           st rs we  reg    value
    vecs[0] = '{OP_STM,  9'h00B, 3'd1, 32'h0000_1000, 0, 0, 1, 4'd1,  32'h0000_100C};
    vecs[1] = '{OP_PUSH, 9'h110, 3'd0, 32'h0000_2000, 0, 0, 1, 4'd13, 32'h0000_1FF8};
    vecs[2] = '{OP_LDM,  9'h006, 3'd2, 32'h0000_4000, 2, 1, 0, 4'd2,  32'h0000_4008};
    vecs[3] = '{OP_POP,  9'h101, 3'd0, 32'h0000_3000, 0, 0, 1, 4'd13, 32'h0000_3008};
    vecs[4] = '{OP_STM,  9'h1FF, 3'd7, 32'h0000_0500, 0, 0, 1, 4'd7,  32'h0000_0520};
    vecs[5] = '{OP_LDM,  9'h081, 3'd3, 32'hFFFF_FFFC, 0, 0, 1, 4'd3,  32'h0000_0004};
    vecs[6] = '{OP_PUSH, 9'h1FF, 3'd0, 32'h0000_0100, 1, 0, 1, 4'd13, 32'h0000_00DC};
    vecs[7] = '{OP_LDM,  9'h100, 3'd0, 32'h0000_7000, 0, 0, 0, 4'd0,  32'h0000_0000};
    vecs[8] = '{OP_LDM,  9'h002, 3'd1, 32'h0000_0010, 1, 0, 0, 4'd1,  32'h0000_0014};
    vecs[9] = '{OP_STM,  9'h001, 3'd0, 32'h0000_1003, 0, 0, 1, 4'd0,  32'h0000_1007};

    #1;
    check_quiet("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) run_vec(rand_vec(), $sformatf("rand%0d", i));

    // Reset in the middle of a stalled STM must silence everything at once.
    @(negedge clk);
    op = OP_STM; reg_list = 9'h0FF; base_rn = 3'd0; base_addr = 32'h0000_8000;
    mem_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("abort pre working", {31'd0, multiple_working}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("abort async");
    @(posedge clk); @(posedge clk); #1;
    check_quiet("abort held");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "after reset");
    run_vec(vecs[5], "after reset wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
